lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit controller between the execute stage and the data-memory port. Accepts one load/store per handshake, checks alignment, builds byte enables and lane-aligned write data, and sequences the memory request/response handshake. Returns sign/zero-extended load data to writeback. Holds the pipeline (busy) while an access is outstanding and flags misaligned, illegal-width and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT before bus error; 0 disables timeout
CNT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  1  execute stage presents access
req_ready  out  1  controller can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_rd  in  5  load destination register
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_addr  out  32  word address, {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-aligned store data
mem_rsp_valid  in  1  read data / write ack, one cycle
mem_rdata  in  32  read word
wb_valid  out  1  one-cycle load result strobe
wb_rd  out  5  load destination
wb_data  out  32  extended load data
done  out  1  one-cycle strobe on any completion (load, store, exception)
busy  out  1  access in flight (state != IDLE)
exc_misalign  out  1  one-cycle misaligned pulse
exc_illegal  out  1  one-cycle illegal funct3 pulse
exc_bus  out  1  one-cycle timeout pulse
exc_addr  out  32  faulting byte address, held until next exception

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1; counter 0; latched request cleared.
- States: IDLE, REQ, WAIT, RESP. Accept on req_valid&&req_ready; opcode, addr, data, rd, offset=addr[1:0] latched.
- Checks at accept: illegal = load funct3 in {011,110,111} or store funct3 >= 011. Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal takes priority. On either: pulse exc_* and done next cycle, exc_addr=req_addr, no memory access, remain IDLE (req_ready drops for that one cycle).
- REQ: mem_req_valid=1; payload stable until mem_req_ready; no abort. SB: be=0001<<off, wdata={4{b}}. SH: be=0011<<off, wdata={2{h}}. SW: be=1111. Loads: be=1111, we=0. On ready -> WAIT, counter cleared.
- WAIT: on mem_rsp_valid -> RESP, latch shifted word (mem_rdata>>(8*off)). Counter +1 per cycle; at TIMEOUT_CYCLES without response -> exc_bus and done pulse, exc_addr=latched addr, -> IDLE.
- RESP: loads: wb_valid=1, wb_rd, wb_data extended per funct3 (LB/LH sign, LBU/LHU zero, LW pass). Stores: done only, wb_valid=0. -> IDLE.
- Latency: accepted in cycle 0 -> mem_req_valid cycle 1; with ready cycle 1 and rsp cycle 2, wb_valid/done in cycle 3. Back-to-back accept possible in cycle 4.
- mem_rsp_valid outside WAIT ignored (incl. late response after timeout or reset). mem_rsp_valid in the same cycle as mem_req_ready is not a valid response (must come >=1 cycle later).
- Reset mid-access: immediate return to IDLE; no done/wb pulse; pending memory transaction dropped.
- wb_data/wb_rd hold last value when wb_valid=0.

Decomposition:
- funct3 encodings (LB..LHU, SB..SW) and state encodings go in defines.vh alongside existing load codes.
- One combinational sub-module natural: lsu_lane_ext (offset shift + sign/zero extension), instantiated in RESP path; FSM, counter and store lane logic in lsu_ctrl.

Test Plan:
- LB addr=0x103, mem_rdata=0x80FF_1234, rsp 1 cycle after ready -> wb_valid cycle 3, wb_data=0xFFFF_FF80, wb_rd=req_rd.
- LHU addr=0x202, mem_rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB addr=0x301, wdata=0x0000_00AB -> mem_be=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x300; mem_req_ready held low 3 cycles, payload stable; done after ack, wb_valid never 1.
- LW addr=0x102 -> exc_misalign pulse, exc_addr=0x102, mem_req_valid stays 0; funct3=011 load -> exc_illegal.
- LW, no mem_rsp_valid, TIMEOUT_CYCLES=16 -> exc_bus 16 cycles after entering WAIT; later stray mem_rsp_valid produces no wb_valid.
- rst_n low while in WAIT -> busy=0, req_ready=1 immediately; next LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and decode helpers for the load/store unit controller.
// Holds funct3 codes, FSM states and the store-lane builders.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [4:0]  rd;
    } lsu_req_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > F3_W;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size comes from the low funct3 bits; sign bit does not matter here.
    function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b1111;
        if (we && f3 == F3_B) be = 4'b0001 << off;
        if (we && f3 == F3_H) be = 4'b0011 << off;
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        logic [31:0] r;
        r = wd;
        if (f3 == F3_B) r = {4{wd[7:0]}};
        if (f3 == F3_H) r = {2{wd[15:0]}};
        return r;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-stage and data-memory handshake bundle for the LSU controller.
// slave = controller view, master = stage/memory side view.
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        done;
    logic        busy;
    logic        exc_misalign;
    logic        exc_illegal;
    logic        exc_bus;
    logic [31:0] exc_addr;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output wb_valid, wb_rd, wb_data,
        output done, busy, exc_misalign, exc_illegal, exc_bus, exc_addr
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  wb_valid, wb_rd, wb_data,
        input  done, busy, exc_misalign, exc_illegal, exc_bus, exc_addr
    );

endinterface

// File: rtl/lsu_ctrl_lane_ext.sv
// Moves the addressed byte/halfword down to lane 0 of a read word
// and sign/zero-extends it according to the load funct3.
module lsu_ctrl_lane_ext
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = sh;
        unique case (1'b1)
            funct3_i == F3_B:  data_o = {{24{sh[7]}}, sh[7:0]};
            funct3_i == F3_H:  data_o = {{16{sh[15]}}, sh[15:0]};
            funct3_i == F3_BU: data_o = {24'd0, sh[7:0]};
            funct3_i == F3_HU: data_o = {16'd0, sh[15:0]};
            default:           data_o = sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accept, check, drive one memory access,
// return extended load data and flag misaligned/illegal/timed-out accesses.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    lsu_req_t         req_q, req_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic             berr_q, berr_d;
    logic [31:0]      exc_addr_q, exc_addr_d;

    logic        exc_any;
    logic        accept;
    logic        ill_in;
    logic        mis_in;
    logic [31:0] ext_data;

    lsu_ctrl_lane_ext u_ext (
        .rdata_i  (bus.mem_rdata),
        .off_i    (req_q.addr[1:0]),
        .funct3_i (req_q.funct3),
        .data_o   (ext_data)
    );

    assign exc_any = mis_q | ill_q | berr_q;
    assign accept  = bus.req_valid && bus.req_ready;
    assign ill_in  = f3_illegal(bus.req_we, bus.req_funct3);
    assign mis_in  = f3_misalign(bus.req_funct3, bus.req_addr[1:0]);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        mis_d      = 1'b0;
        ill_d      = 1'b0;
        berr_d     = 1'b0;
        exc_addr_d = exc_addr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_d.we     = bus.req_we;
                    req_d.funct3 = bus.req_funct3;
                    req_d.addr   = bus.req_addr;
                    req_d.rd     = bus.req_rd;
                    if (ill_in || mis_in) begin
                        ill_d      = ill_in;
                        mis_d      = !ill_in;
                        exc_addr_d = bus.req_addr;
                    end else begin
                        be_d = lane_be(bus.req_we, bus.req_funct3,
                                       bus.req_addr[1:0]);
                        wdata_d = bus.req_we ?
                            lane_wdata(bus.req_funct3, bus.req_wdata) : 32'd0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the last counted cycle still wins.
                if (bus.mem_rsp_valid) begin
                    state_d = S_RESP;
                    if (!req_q.we) begin
                        wb_data_d = ext_data;
                        wb_rd_d   = req_q.rd;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    berr_d     = 1'b1;
                    exc_addr_d = req_q.addr;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
            berr_q     <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
            berr_q     <= berr_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Ready also drops for the single cycle an exception pulse is shown.
    assign bus.req_ready     = (state_q == S_IDLE) && !exc_any;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_we        = (state_q == S_REQ) && req_q.we;
    assign bus.mem_be        = be_q;
    assign bus.mem_addr      = {req_q.addr[31:2], 2'b00};
    assign bus.mem_wdata     = wdata_q;
    assign bus.wb_valid      = (state_q == S_RESP) && !req_q.we;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.done          = (state_q == S_RESP) || exc_any;
    assign bus.exc_misalign  = mis_q;
    assign bus.exc_illegal   = ill_q;
    assign bus.exc_bus       = berr_q;
    assign bus.exc_addr      = exc_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scripted timeline model per access,
// one negedge compare process, directed cases then random traffic.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        e_rdy, e_busy, e_mrv, e_mwe, e_wbv, e_done;
    logic        e_mis, e_ill, e_bus;
    logic [3:0]  e_be;
    logic [31:0] e_maddr, e_mwdata, e_wbd, e_exa;
    logic [4:0]  e_wbrd;
    bit          chk_on = 1'b0;

    logic [31:0] m_wbd;
    logic [4:0]  m_wbrd;
    logic [31:0] m_exa;

    task automatic chk1(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk1("req_ready", bus.req_ready, e_rdy);
            chk1("busy", bus.busy, e_busy);
            chk1("mem_req_valid", bus.mem_req_valid, e_mrv);
            chk1("mem_we", bus.mem_we, e_mwe);
            chk1("wb_valid", bus.wb_valid, e_wbv);
            chk1("done", bus.done, e_done);
            chk1("exc_misalign", bus.exc_misalign, e_mis);
            chk1("exc_illegal", bus.exc_illegal, e_ill);
            chk1("exc_bus", bus.exc_bus, e_bus);
            chk32("wb_data", bus.wb_data, e_wbd);
            chk32("wb_rd", 32'(bus.wb_rd), 32'(e_wbrd));
            chk32("exc_addr", bus.exc_addr, e_exa);
            if (e_mrv) begin
                chk32("mem_addr", bus.mem_addr, e_maddr);
                chk32("mem_be", 32'(bus.mem_be), 32'(e_be));
                if (e_mwe) chk32("mem_wdata", bus.mem_wdata, e_mwdata);
            end
        end
    end

    function automatic logic [3:0] m_be(bit we, logic [2:0] f3, logic [31:0] a);
        int off = int'(a[1:0]);
        if (!we) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a,
                                           logic [31:0] rd);
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] h;
        s = rd >> (8 * int'(a[1:0]));
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return s;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_rdy = 1'b1; e_busy = 1'b0; e_mrv = 1'b0; e_mwe = 1'b0;
        e_wbv = 1'b0; e_done = 1'b0;
        e_mis = 1'b0; e_ill = 1'b0; e_bus = 1'b0;
        e_be = 4'h0; e_maddr = 32'd0; e_mwdata = 32'd0;
        e_wbd = m_wbd; e_wbrd = m_wbrd; e_exa = m_exa;
    endtask

    // Only used while the controller cannot accept: all of it must be ignored.
    task automatic noise();
        bus.req_valid     = 1'($urandom_range(0, 1));
        bus.req_we        = 1'($urandom_range(0, 1));
        bus.req_funct3    = 3'($urandom_range(0, 7));
        bus.req_addr      = $urandom;
        bus.req_wdata     = $urandom;
        bus.req_rd        = 5'($urandom_range(0, 31));
        bus.mem_req_ready = 1'($urandom_range(0, 1));
        bus.mem_rsp_valid = 1'($urandom_range(0, 1));
        bus.mem_rdata     = $urandom;
    endtask

    task automatic gap(int n);
        for (int i = 0; i < n; i++) begin
            idle_exp();
            noise();
            bus.req_valid = 1'b0;
            tick();
        end
    endtask

    // rdly: cycles mem_req_ready stays low; wdly: WAIT cycles before the
    // response (-1 = never); abort: WAIT cycle index at which reset hits.
    task automatic do_txn(bit we, logic [2:0] f3, logic [31:0] addr,
                          logic [31:0] wdata, logic [4:0] rd,
                          int rdly, int wdly, logic [31:0] rdata,
                          int abort, output logic [31:0] wbexp);
        bit bad_f3;
        bit mis;
        int sz;
        bit got;
        idle_exp();
        noise();
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        tick();
        bad_f3 = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << int'(f3[1:0]);
        mis = (int'(addr[1:0]) % sz) != 0;
        if (bad_f3 || mis) begin
            m_exa = addr;
            idle_exp();
            e_rdy = 1'b0; e_done = 1'b1;
            e_ill = bad_f3; e_mis = !bad_f3;
            noise();
            tick();
            wbexp = m_wbd;
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            idle_exp();
            e_rdy = 1'b0; e_busy = 1'b1; e_mrv = 1'b1; e_mwe = we;
            e_maddr = addr & 32'hFFFF_FFFC;
            e_be = m_be(we, f3, addr);
            e_mwdata = m_wd(f3, wdata);
            noise();
            bus.mem_req_ready = (i == rdly);
            tick();
        end
        got = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j == abort) begin
                m_wbd = 32'd0; m_wbrd = 5'd0; m_exa = 32'd0;
                idle_exp();
                noise();
                bus.req_valid = 1'b0;
                bus.mem_rsp_valid = 1'b1;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                wbexp = m_wbd;
                return;
            end
            idle_exp();
            e_rdy = 1'b0; e_busy = 1'b1;
            noise();
            bus.mem_rsp_valid = (j == wdly);
            bus.mem_rdata = rdata;
            tick();
            if (j == wdly) begin
                got = 1'b1;
                break;
            end
        end
        idle_exp();
        e_rdy = 1'b0; e_done = 1'b1;
        if (got) begin
            if (!we) begin
                m_wbd = m_load(f3, addr, rdata);
                m_wbrd = rd;
            end
            idle_exp();
            e_rdy = 1'b0; e_done = 1'b1; e_busy = 1'b1; e_wbv = !we;
        end else begin
            m_exa = addr;
            idle_exp();
            e_rdy = 1'b0; e_done = 1'b1; e_bus = 1'b1;
        end
        noise();
        tick();
        wbexp = m_wbd;
    endtask

    logic [31:0] w;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata = 32'd0;
        m_wbd = 32'd0; m_wbrd = 5'd0; m_exa = 32'd0;
        idle_exp();
        #1;
        chk_on = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        gap(2);

        do_txn(1'b0, 3'd0, 32'h103, 32'd0, 5'd7, 0, 0, 32'h80FF_1234, -1, w);
        chk32("pin_lb", w, 32'hFFFF_FF80);
        chk32("lb_wb_data", bus.wb_data, 32'hFFFF_FF80);
        chk32("lb_wb_rd", 32'(bus.wb_rd), 32'd7);

        do_txn(1'b0, 3'd5, 32'h202, 32'd0, 5'd3, 1, 1, 32'hBEEF_0000, -1, w);
        chk32("pin_lhu", w, 32'h0000_BEEF);
        do_txn(1'b0, 3'd1, 32'h202, 32'd0, 5'd4, 0, 2, 32'hBEEF_0000, -1, w);
        chk32("pin_lh", w, 32'hFFFF_BEEF);

        chk32("pin_sb_be", 32'(m_be(1'b1, 3'd0, 32'h301)), 32'h2);
        chk32("pin_sb_wd", m_wd(3'd0, 32'hAB), 32'hABAB_ABAB);
        do_txn(1'b1, 3'd0, 32'h301, 32'hAB, 5'd9, 3, 1, 32'd0, -1, w);
        chk32("sb_wb_hold", bus.wb_data, 32'hFFFF_BEEF);

        do_txn(1'b0, 3'd2, 32'h102, 32'd0, 5'd1, 0, 0, 32'd0, -1, w);
        chk32("mis_exa", bus.exc_addr, 32'h102);
        do_txn(1'b0, 3'd3, 32'h400, 32'd0, 5'd1, 0, 0, 32'd0, -1, w);
        chk32("ill_exa", bus.exc_addr, 32'h400);

        do_txn(1'b0, 3'd2, 32'h500, 32'd0, 5'd2, 0, -1, 32'd0, -1, w);
        chk32("to_exa", bus.exc_addr, 32'h500);
        gap(4);

        do_txn(1'b0, 3'd2, 32'h600, 32'd0, 5'd5, 0, -1, 32'd0, 3, w);
        gap(1);
        do_txn(1'b0, 3'd2, 32'h604, 32'd0, 5'd6, 0, 0, 32'h1234_5678, -1, w);
        chk32("rst_lw", bus.wb_data, 32'h1234_5678);

        for (int k = 0; k < 300; k++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            int          wd;
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                 : (we ? 3'($urandom_range(0, 2))
                       : 3'($urandom_range(0, 5)));
            if (!we && f3 == 3'd3) f3 = 3'd2;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            wd = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 5);
            do_txn(we, f3, a, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3), wd, $urandom, -1, w);
            gap($urandom_range(0, 2));
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
